serial_out: RTL and testbench
=============================

# serial_out

Memory-mapped serial output device that sits directly downstream of the CPU's device-output path. It captures bytes written by the CPU (DI strobe with matching address) into a small FIFO, and serializes them LSB-first as 8N1 frames on `tx`. It also answers CPU status reads (DO strobe) so software can poll before writing.

## Interface
Parameters:
- `ADDR`, 16'h0002: device address; writes and reads are decoded against the full 16-bit `addr`.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; range 1..65535.
- `FIFO_DEPTH`, 8: byte FIFO entries; power of two, 2..256.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset_bar`  in  1: asynchronous, active-low reset.
- `addr`  in  16: CPU address bus.
- `bus_in`  in  16: CPU data bus; only `bus_in[7:0]` is captured.
- `DI`  in  1: CPU device-input strobe, meaning the CPU writes to a device.
- `DO`  in  1: CPU device-output strobe, meaning the CPU reads from a device.
- `bus_out`  out  16: status word; zero when `bus_oe` is low.
- `bus_oe`  out  1: combinational `DO && addr==ADDR`.
- `tx`  out  1: serial line; idles high.
- `full`  out  1: FIFO count == FIFO_DEPTH.
- `empty`  out  1: FIFO count == 0.

## Operation
- Reset values while `reset_bar` is low, applied asynchronously:
  - `tx`=1, FIFO count=0, `empty`=1, `full`=0, overflow=0.
  - FSM in IDLE, bit counter and baud counter = 0.
- Write: on a rising edge with `DI && addr==ADDR`, push `bus_in[7:0]`.
  - If the FIFO is full and no pop occurs on that edge, the byte is dropped and sticky `overflow` is set.
- Status word, valid whenever `bus_oe` is high:
  - bit0 `empty`, bit1 `full`, bit2 `busy` (FSM not IDLE), bit3 `overflow`, bits7:4 = 0.
  - bits15:8 = FIFO count, saturating at 255.
- Status read side effect: a rising edge with `bus_oe` high clears `overflow`.
  - If an overflow occurs on that same edge, set wins.
- The device never drives the bus on DI, and never captures data on DO.
- Transmit FSM:
  - IDLE: `tx`=1. If FIFO is non-empty at the edge, pop the head into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; after bit 7, go to PARITY (if compiled in) else STOP.
  - PARITY: even-parity bit held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- IDLE lasts at least one cycle between frames.
- Simultaneous push and pop on one edge: both happen and the count is unchanged. This holds when full.
- There is no bypass. A pop requires count>0 before the edge, so a byte written at edge N is popped at N+1 at the earliest.
- Pointers wrap modulo FIFO_DEPTH; count has log2(FIFO_DEPTH)+1 bits.

## Timing
- `tx` is registered. The baud counter is reset on every state entry.
- Write-to-start latency:
  - A byte written at edge N into an empty FIFO while IDLE is popped at edge N+1.
  - `tx` falls after edge N+1.
- Frame length is 10×CLKS_PER_BIT cycles without parity and 11×CLKS_PER_BIT with parity.
- Back-to-back frame period is 10×CLKS_PER_BIT+1 cycles (+CLKS_PER_BIT with parity).
- `full` and `empty` update on the edge that changes the count.
- Reset asserted mid-frame: `tx` goes high immediately and queued bytes are discarded.
- After reset release, the first edge that sees `reset_bar` high behaves as normal.

## Configuration
- `SERIAL_OUT_PARITY_EN` defined:
  - The PARITY state is included, carrying even parity (XOR of the 8 data bits).
  - Status bit4 reads 1.
- Not defined:
  - The PARITY state and its logic are absent; frames are 8N1.
  - Status bit4 reads 0.

## Test plan
- Reset, then write 0x55 at ADDR with CLKS_PER_BIT=4:
  - `tx` low for cycles 1–4 after the write edge.
  - Then data bits 1,0,1,0,1,0,1,0, 4 cycles each.
  - Then high from cycle 37 onward; `busy` clears at cycle 41.
- Write 0xA3 to ADDR+1: no push, `empty` stays 1, `tx` stays 1.
  - A DO read at ADDR returns 0x0001 with `bus_oe`=1.
  - `bus_out`=0 when `addr`≠ADDR.
- Write 9 bytes 0x00..0x08 on consecutive cycles while the first is still in START:
  - `full`=1 after the 9th write edge, with count 8; no overflow.
  - A 10th write sets `overflow`; status reads 0x080E.
  - After that read, status reads 0x080 6.
- Queue 0x01 and 0x80 back-to-back:
  - Second start bit begins exactly 41 cycles after the first; bit patterns are LSB-first.
- Assert `reset_bar` low mid-DATA of 0xFF with 3 bytes queued:
  - `tx`=1 immediately; after release, `empty`=1 and no further frames.
- With `SERIAL_OUT_PARITY_EN`, send 0x07:
  - Parity bit = 1 after bit 7; frame is 44 cycles; status bit4 = 1.

Source files
------------

// File: rtl/serial_out.sv
// serial_out
//   Memory-mapped serial transmitter. CPU writes (DI strobe, addr == ADDR)
//   push bus_in[7:0] into a byte FIFO; a transmit FSM pops bytes and sends
//   them LSB-first as 8N1 frames (8E1 when SERIAL_OUT_PARITY_EN is defined)
//   on tx. CPU reads (DO strobe, addr == ADDR) return a status word.
//
//   Build option: `define SERIAL_OUT_PARITY_EN adds an even-parity bit after
//   the data bits and sets status bit4.
//
//   Parameters
//     ADDR          device address, full 16-bit decode
//     CLKS_PER_BIT  clock cycles per serial bit (1..65535)
//     FIFO_DEPTH    FIFO entries, power of two (2..256)
//
//   Ports
//     clk        in   system clock, rising edge
//     reset_bar  in   asynchronous active-low reset
//     addr       in   CPU address bus
//     bus_in     in   CPU data bus, low byte captured on writes
//     DI         in   CPU write strobe
//     DO         in   CPU read strobe
//     bus_out    out  status word, zero unless bus_oe
//     bus_oe     out  DO && addr == ADDR
//     tx         out  serial line, idles high (registered)
//     full       out  FIFO holds FIFO_DEPTH bytes
//     empty      out  FIFO holds no bytes
//
//   Status word: [15:8] count (saturating at 255), [4] parity built in,
//   [3] overflow (sticky, cleared by a status read), [2] busy,
//   [1] full, [0] empty.

module serial_out #(
  parameter logic [15:0] ADDR         = 16'h0002,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset_bar,
  input  logic [15:0] addr,
  input  logic [15:0] bus_in,
  input  logic        DI,
  input  logic        DO,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  output logic        tx,
  output logic        full,
  output logic        empty
);

  localparam int unsigned   AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned   CW        = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);
`ifdef SERIAL_OUT_PARITY_EN
  localparam logic          PARITY_FLAG = 1'b1;
`else
  localparam logic          PARITY_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERIAL_OUT_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t         state_q, state_d;
  logic [15:0]    baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           tx_q, tx_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic [7:0]     mem_q [FIFO_DEPTH];
`ifdef SERIAL_OUT_PARITY_EN
  logic           par_q, par_d;
`endif

  // ---------------------------------------------------------------------
  // Decode and FIFO control
  // ---------------------------------------------------------------------
  logic           dev_hit;
  logic           push_req;
  logic           push;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic           overflow_set;
  logic           busy;
  logic           baud_last;
  logic [7:0]     head;
  logic [8:0]     count_ext;
  logic [7:0]     count_sat;
  logic           unused_hi;

  assign dev_hit    = (addr == ADDR);
  assign push_req   = DI && dev_hit;
  assign bus_oe     = DO && dev_hit;
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign busy       = (state_q != S_IDLE);
  assign baud_last  = (baud_q == BAUD_LAST);
  assign unused_hi  = ^bus_in[15:8];

  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push         = push_req && (!fifo_full || pop);
  assign overflow_set = push_req && fifo_full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A status read clears overflow, but a new overflow on the same edge wins.
    if (overflow_set) begin
      ovf_d = 1'b1;
    end else if (bus_oe) begin
      ovf_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Transmit FSM
  // tx is registered: each transition computes the line level for the
  // state being entered, so tx changes on the same edge as the state.
  // The shift register moves one place per data bit, which keeps the
  // next bit to send at shreg_q[1].
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef SERIAL_OUT_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = head;
`ifdef SERIAL_OUT_PARITY_EN
          par_d   = ^head;
`endif
          state_d = S_START;
          baud_d  = '0;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef SERIAL_OUT_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

`ifdef SERIAL_OUT_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          state_d = S_STOP;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif

      S_STOP: begin
        if (baud_last) begin
          state_d = S_IDLE;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
`ifdef SERIAL_OUT_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
`ifdef SERIAL_OUT_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus_in[7:0];
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign count_ext = 9'(count_q);
  assign count_sat = count_ext[8] ? 8'hFF : count_ext[7:0];

  assign bus_out = bus_oe ? {count_sat, 3'b000, PARITY_FLAG, ovf_q, busy, fifo_full, fifo_empty}
                          : '0;
  assign tx      = tx_q;
  assign full    = fifo_full;
  assign empty   = fifo_empty;

endmodule

// File: tb/tb_serial_out.sv
`timescale 1ns/1ps
module tb_serial_out;

  localparam logic [15:0] ADDR  = 16'h0002;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
`ifdef SERIAL_OUT_PARITY_EN
  localparam int          NB    = 11;
  localparam logic        PBIT  = 1'b1;
`else
  localparam int          NB    = 10;
  localparam logic        PBIT  = 1'b0;
`endif
  localparam int          FL    = NB * CPB;

  logic        clk       = 1'b0;
  logic        reset_bar = 1'b0;
  logic [15:0] addr      = 16'h0000;
  logic [15:0] bus_in    = 16'h0000;
  logic        DI        = 1'b0;
  logic        DO        = 1'b0;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic        tx;
  logic        full;
  logic        empty;

  serial_out #(
    .ADDR(ADDR),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_bar(reset_bar),
    .addr(addr),
    .bus_in(bus_in),
    .DI(DI),
    .DO(DO),
    .bus_out(bus_out),
    .bus_oe(bus_oe),
    .tx(tx),
    .full(full),
    .empty(empty)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: a byte queue plus the timeline of the frame in
  // flight. A frame popped at edge P drives bit j of its frame pattern
  // during the cycles after edges P+j*CPB .. P+(j+1)*CPB-1; the line is
  // idle for one cycle after the frame before another pop can happen.
  // ---------------------------------------------------------------------
  int          ecnt    = 0;
  logic [7:0]  mq[$];
  bit          m_ovf   = 1'b0;
  bit          m_act   = 1'b0;
  int          m_pop_e = 0;
  logic [10:0] m_bits  = '1;
  logic        m_tx    = 1'b1;
  bit          m_busy  = 1'b0;

  always @(posedge clk or negedge reset_bar) begin : model
    bit         do_pop;
    bit         set_ovf;
    logic [7:0] b;
    if (!reset_bar) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_act  = 1'b0;
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else begin
      ecnt++;
      do_pop = (mq.size() > 0) && (!m_act || (ecnt >= m_pop_e + FL + 1));
      if (do_pop) begin
        b       = mq.pop_front();
        m_act   = 1'b1;
        m_pop_e = ecnt;
`ifdef SERIAL_OUT_PARITY_EN
        m_bits  = {1'b1, ^b, b, 1'b0};
`else
        m_bits  = {1'b1, 1'b1, b, 1'b0};
`endif
      end
      set_ovf = 1'b0;
      if (DI && addr == ADDR) begin
        if (mq.size() < DEPTH) mq.push_back(bus_in[7:0]);
        else                   set_ovf = 1'b1;
      end
      if (set_ovf)                  m_ovf = 1'b1;
      else if (DO && addr == ADDR)  m_ovf = 1'b0;
      if (m_act && (ecnt - m_pop_e) < FL) begin
        m_busy = 1'b1;
        m_tx   = m_bits[(ecnt - m_pop_e) / CPB];
      end else begin
        m_busy = 1'b0;
        m_tx   = 1'b1;
      end
    end
  end

  function automatic logic [15:0] model_status();
    int         n;
    logic [7:0] c;
    n = mq.size();
    c = (n > 255) ? 8'hFF : 8'(n);
    return {c, 3'b000, PBIT, m_ovf, m_busy, (n == DEPTH), (n == 0)};
  endfunction

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin : compare
    logic oe;
    oe = DO && (addr == ADDR);
    chk("tx",      16'(tx),     16'(m_tx));
    chk("empty",   16'(empty),  16'(mq.size() == 0));
    chk("full",    16'(full),   16'(mq.size() == DEPTH));
    chk("bus_oe",  16'(bus_oe), 16'(oe));
    chk("bus_out", bus_out,     oe ? model_status() : 16'h0000);
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Stimulus. Inputs change 2 ns after each rising edge.
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    DI = 1'b0; DO = 1'b0; addr = 16'h0000; bus_in = 16'h0000;
  endtask

  logic        txlog [0:127];
  logic [15:0] stlog [0:127];
  logic [7:0]  pat;
  logic [15:0] st_idle;
  int          lows;
  int          waited;

  initial begin : stim
`ifdef SERIAL_OUT_PARITY_EN
    st_idle = 16'h0011;
`else
    st_idle = 16'h0001;
`endif
    // Reset
    quiet();
    repeat (3) step();
    chk("rst_tx",    16'(tx),    16'h0001);
    chk("rst_empty", 16'(empty), 16'h0001);
    chk("rst_full",  16'(full),  16'h0000);
    reset_bar = 1'b1;
    DO = 1'b1; addr = ADDR;
    @(negedge clk);
    chk("rst_status", bus_out, st_idle);
    step();

    // Single frame of 0x55, status held on the bus to watch busy
    quiet();
    DI = 1'b1; addr = ADDR; bus_in = 16'hAB55;
    step();
    DI = 1'b0; DO = 1'b1; addr = ADDR;
    @(negedge clk);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      txlog[k] = tx;
      stlog[k] = bus_out;
    end
    step();
    pat = 8'h55;
    for (int k = 1; k <= 4; k++) chk("55_start", 16'(txlog[k]), 16'h0000);
    for (int j = 0; j < 8; j++)  chk("55_data", 16'(txlog[4 + 4*j + 2]), 16'(pat[j]));
`ifdef SERIAL_OUT_PARITY_EN
    chk("55_parity", 16'(txlog[37]), 16'h0000);
    chk("55_stop",   16'(txlog[41]), 16'h0001);
    chk("55_busy44", 16'(stlog[44][2]), 16'h0001);
    chk("55_busy45", 16'(stlog[45][2]), 16'h0000);
`else
    chk("55_stop",   16'(txlog[37]), 16'h0001);
    chk("55_busy40", 16'(stlog[40][2]), 16'h0001);
    chk("55_busy41", 16'(stlog[41][2]), 16'h0000);
`endif
    chk("55_parflag", 16'(stlog[10][4]), 16'(PBIT));
    repeat (4) step();

    // Write to the wrong address, then status reads
    quiet();
    DI = 1'b1; addr = ADDR + 16'd1; bus_in = 16'h00A3;
    step();
    DI = 1'b0; DO = 1'b1; addr = ADDR;
    @(negedge clk);
    chk("a3_empty",  16'(empty),  16'h0001);
    chk("a3_tx",     16'(tx),     16'h0001);
    chk("a3_status", bus_out,     st_idle);
    chk("a3_oe",     16'(bus_oe), 16'h0001);
    step();
    addr = ADDR + 16'd1;
    @(negedge clk);
    chk("miss_bus", bus_out,     16'h0000);
    chk("miss_oe",  16'(bus_oe), 16'h0000);
    step();

    // Fill the FIFO, then overflow it
    quiet();
    for (int i = 0; i < 10; i++) begin
      DI = 1'b1; addr = ADDR; bus_in = 16'(i);
      if (i == 9) begin
        DO = 1'b1;
        @(negedge clk);
        chk("fill_full",   16'(full), 16'h0001);
        chk("fill_status", bus_out,   16'h0806 | 16'(PBIT) << 4);
      end
      step();
    end
    DI = 1'b0; DO = 1'b1; addr = ADDR;
    @(negedge clk);
    chk("ovf_status", bus_out, 16'h080E | 16'(PBIT) << 4);
    step();
    @(negedge clk);
    chk("ovf_clear", bus_out, 16'h0806 | 16'(PBIT) << 4);
    step();
    quiet();
    repeat (9 * (FL + 1) + 10) step();
    chk("drain_empty", 16'(empty), 16'h0001);

    // Back-to-back frames 0x01, 0x80
    DI = 1'b1; addr = ADDR; bus_in = 16'h0001;
    step();
    bus_in = 16'h0080;
    step();
    quiet();
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      txlog[k] = tx;
    end
    step();
    chk("b2b_start1", 16'(txlog[1]), 16'h0000);
    chk("b2b_01_b0",  16'(txlog[5]), 16'h0001);
    chk("b2b_01_b1",  16'(txlog[9]), 16'h0000);
    chk("b2b_gap",    16'(txlog[FL + 1]), 16'h0001);
    chk("b2b_start2", 16'(txlog[FL + 2]), 16'h0000);
    chk("b2b_80_b0",  16'(txlog[FL + 2 + CPB]), 16'h0000);
    chk("b2b_80_b7",  16'(txlog[FL + 2 + 8*CPB]), 16'h0001);
    repeat (10) step();

    // Reset mid-DATA of 0xFF with three bytes queued
    DI = 1'b1; addr = ADDR;
    bus_in = 16'h00FF; step();
    bus_in = 16'h0011; step();
    bus_in = 16'h0022; step();
    bus_in = 16'h0033; step();
    quiet();
    repeat (10) step();
    reset_bar = 1'b0;
    #1;
    chk("midrst_tx",    16'(tx),    16'h0001);
    chk("midrst_empty", 16'(empty), 16'h0001);
    step();
    step();
    reset_bar = 1'b1;
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (tx !== 1'b1) lows++;
    end
    chk("postrst_lows",  16'(lows),  16'h0000);
    chk("postrst_empty", 16'(empty), 16'h0001);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 9))
        0:       addr = ADDR + 16'd1;
        1:       addr = ADDR - 16'd1;
        default: addr = ADDR;
      endcase
      DI     = ($urandom_range(0, 99) < 30);
      DO     = ($urandom_range(0, 99) < 20);
      bus_in = 16'($urandom);
      step();
    end
    quiet();

    // Asynchronous reset while the line is low
    waited = 0;
    DI = 1'b1; addr = ADDR; bus_in = 16'h0000;
    step();
    quiet();
    while (tx !== 1'b0 && waited < 2000) begin
      step();
      waited++;
    end
    chk("wait_low_timeout", 16'(waited < 2000), 16'h0001);
    reset_bar = 1'b0;
    #1;
    chk("lowrst_tx", 16'(tx), 16'h0001);
    step();
    reset_bar = 1'b1;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
